// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM cyclic-prefix insert/remove datapath:
// default geometry, CP-remover state codes and sample I/Q field positions.
package ofdm_pkg;

  // Default symbol geometry, common to the CP adder and the CP remover
  localparam int DATA_W_DEF = 22;
  localparam int NFFT_DEF   = 64;
  localparam int CP_LEN_DEF = 16;

  // Packed sample layout: I in the upper half, Q in the lower half
  localparam int I_MSB = 21;
  localparam int I_LSB = 11;
  localparam int Q_MSB = 10;
  localparam int Q_LSB = 0;

  // CP remover state codes
  typedef logic [1:0] cp_state_t;
  localparam cp_state_t ST_IDLE = 2'd0;
  localparam cp_state_t ST_SKIP = 2'd1;
  localparam cp_state_t ST_PASS = 2'd2;
  localparam cp_state_t ST_DROP = 2'd3;

  // Counter width able to hold both the prefix count and the useful-sample index
  function automatic int cnt_width(input int nfft, input int cp_len);
    int span;
    span = (nfft > cp_len + 1) ? nfft : cp_len + 1;
    return (span > 2) ? $clog2(span) : 1;
  endfunction

endpackage

// File: rtl/st_skid_buffer.sv
// Generic 2-entry Avalon-ST skid buffer. The head register drives the
// source side directly; the skid register catches a beat pushed while the
// head is stalled. in_ready is a register meaning "a slot will be free",
// so there is no combinational path from out_ready to in_ready.
module st_skid_buffer #(
  parameter int PAYLOAD_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 out_ready
);

  logic                 head_valid_r;
  logic [PAYLOAD_W-1:0] head_r;
  logic                 skid_valid_r;
  logic [PAYLOAD_W-1:0] skid_r;
  logic                 in_ready_r;

  logic                 head_valid_n_s;
  logic [PAYLOAD_W-1:0] head_n_s;
  logic                 skid_valid_n_s;
  logic [PAYLOAD_W-1:0] skid_n_s;
  logic                 push_s;
  logic                 pop_s;

  assign push_s = in_valid && in_ready_r;
  assign pop_s  = head_valid_r && out_ready;

  // Next-state of the two slots: the head refills from skid first, then from the input
  always_comb begin
    head_valid_n_s = head_valid_r;
    head_n_s       = head_r;
    skid_valid_n_s = skid_valid_r;
    skid_n_s       = skid_r;
    if (pop_s || !head_valid_r) begin
      if (skid_valid_r) begin
        head_valid_n_s = 1'b1;
        head_n_s       = skid_r;
        if (push_s) begin
          skid_valid_n_s = 1'b1;
          skid_n_s       = in_payload;
        end else begin
          skid_valid_n_s = 1'b0;
        end
      end else begin
        head_valid_n_s = push_s;
        if (push_s) begin
          head_n_s = in_payload;
        end else begin
          head_n_s = head_r;
        end
      end
    end else begin
      if (push_s) begin
        skid_valid_n_s = 1'b1;
        skid_n_s       = in_payload;
      end else begin
        skid_valid_n_s = skid_valid_r;
      end
    end
  end

  // Slot registers and the registered free-slot flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid_r <= 1'b0;
      head_r       <= '0;
      skid_valid_r <= 1'b0;
      skid_r       <= '0;
      in_ready_r   <= 1'b0;
    end else begin
      head_valid_r <= head_valid_n_s;
      head_r       <= head_n_s;
      skid_valid_r <= skid_valid_n_s;
      skid_r       <= skid_n_s;
      in_ready_r   <= !(head_valid_n_s && skid_valid_n_s);
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = head_valid_r;
  assign out_payload = head_r;

endmodule

// File: rtl/ofdm_cp_remover.sv
// OFDM cyclic-prefix remover. Strips the first CP_LEN samples of every
// sop-delimited symbol, forwards the NFFT useful samples with regenerated
// sop/eop through a 2-entry skid buffer, and flags/counts malformed packets.
module ofdm_cp_remover
  import ofdm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NFFT   = NFFT_DEF,
  parameter int CP_LEN = CP_LEN_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] asi_in0_data,
  input  logic              asi_in0_valid,
  input  logic              asi_in0_startofpacket,
  input  logic              asi_in0_endofpacket,
  output logic              asi_in0_ready,
  output logic [DATA_W-1:0] aso_out0_data,
  output logic              aso_out0_valid,
  output logic              aso_out0_startofpacket,
  output logic              aso_out0_endofpacket,
  input  logic              aso_out0_ready,
  output logic              err_pulse,
  output logic [15:0]       err_count
);

  localparam int               CNT_W     = cnt_width(NFFT, CP_LEN);
  localparam logic [CNT_W-1:0] CP_LAST   = CNT_W'(CP_LEN - 1);
  localparam logic [CNT_W-1:0] NFFT_LAST = CNT_W'(NFFT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               CP_ONE    = (CP_LEN == 1);

  cp_state_t        state_r;
  cp_state_t        state_n_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_n_s;
  logic             accept_s;
  logic             fwd_s;
  logic             fwd_sop_s;
  logic             fwd_eop_s;
  logic             err_s;
  logic             in_ready_s;
  logic             err_pulse_r;
  logic [15:0]      err_count_r;
  logic [DATA_W+1:0] fwd_payload_s;
  logic [DATA_W+1:0] out_payload_s;

  assign accept_s = asi_in0_valid && in_ready_s;

  // Symbol framing FSM: decides per accepted beat whether to drop or forward it
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    fwd_s     = 1'b0;
    fwd_sop_s = 1'b0;
    fwd_eop_s = 1'b0;
    err_s     = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (asi_in0_startofpacket && asi_in0_endofpacket) begin
            // single-beat runt: nothing to strip, nothing to forward
            err_s = 1'b1;
          end else if (asi_in0_startofpacket) begin
            if (CP_ONE) begin
              state_n_s = ST_PASS;
              cnt_n_s   = CNT_ZERO;
            end else begin
              state_n_s = ST_SKIP;
              cnt_n_s   = CNT_ONE;
            end
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_SKIP: begin
          if (asi_in0_endofpacket) begin
            err_s     = 1'b1;
            state_n_s = ST_IDLE;
            cnt_n_s   = CNT_ZERO;
          end else if (asi_in0_startofpacket) begin
            // a fresh symbol start re-anchors the prefix count
            err_s   = 1'b1;
            cnt_n_s = CNT_ONE;
          end else if (cnt_r == CP_LAST) begin
            state_n_s = ST_PASS;
            cnt_n_s   = CNT_ZERO;
          end else begin
            cnt_n_s = cnt_r + CNT_ONE;
          end
        end
        ST_PASS: begin
          fwd_s     = 1'b1;
          fwd_sop_s = (cnt_r == CNT_ZERO);
          if (asi_in0_endofpacket) begin
            fwd_eop_s = 1'b1;
            err_s     = (cnt_r != NFFT_LAST) || asi_in0_startofpacket;
            state_n_s = ST_IDLE;
            cnt_n_s   = CNT_ZERO;
          end else if (cnt_r == NFFT_LAST) begin
            // symbol is complete but input has not ended: close it and drain
            fwd_eop_s = 1'b1;
            err_s     = 1'b1;
            state_n_s = ST_DROP;
            cnt_n_s   = CNT_ZERO;
          end else begin
            err_s   = asi_in0_startofpacket;
            cnt_n_s = cnt_r + CNT_ONE;
          end
        end
        ST_DROP: begin
          if (asi_in0_endofpacket) begin
            state_n_s = ST_IDLE;
          end else begin
            state_n_s = ST_DROP;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
          cnt_n_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // FSM state and beat counter
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  // Error pulse and saturating error counter; one event per accepted beat at most
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      err_pulse_r <= 1'b0;
      err_count_r <= 16'h0000;
    end else begin
      err_pulse_r <= err_s;
      if (err_s && (err_count_r != 16'hFFFF)) begin
        err_count_r <= err_count_r + 16'h0001;
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

  assign fwd_payload_s = {asi_in0_data, fwd_sop_s, fwd_eop_s};

  st_skid_buffer #(
    .PAYLOAD_W (DATA_W + 2)
  ) u_out_buf (
    .clk         (clk_clk),
    .rst         (reset_reset),
    .in_valid    (fwd_s),
    .in_payload  (fwd_payload_s),
    .in_ready    (in_ready_s),
    .out_valid   (aso_out0_valid),
    .out_payload (out_payload_s),
    .out_ready   (aso_out0_ready)
  );

  assign asi_in0_ready          = in_ready_s;
  assign aso_out0_data          = out_payload_s[DATA_W+1:2];
  assign aso_out0_startofpacket = out_payload_s[1];
  assign aso_out0_endofpacket   = out_payload_s[0];
  assign err_pulse              = err_pulse_r;
  assign err_count              = err_count_r;

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Scoreboard bench for ofdm_cp_remover: packets are described by their
// eop position and optional stray-sop position; the expected output and
// error count are computed per packet from the framing rules.
module tb_ofdm_cp_remover;
  import ofdm_pkg::*;

  localparam int DW = 22;
  localparam int NF = 64;
  localparam int CP = 16;

  typedef logic [DW+1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic          out_ready = 1'b1;
  logic          err_pulse;
  logic [15:0]   err_count;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    model_errs = 0;
  int    pulses_seen = 0;
  int    out_total = 0;
  int    in_stalls = 0;
  bit    rnd_ready = 1'b0;
  bit    gaps_on = 1'b0;

  ofdm_cp_remover #(.DATA_W(DW), .NFFT(NF), .CP_LEN(CP)) dut (
    .clk_clk                (clk),
    .reset_reset            (rst),
    .asi_in0_data           (in_data),
    .asi_in0_valid          (in_valid),
    .asi_in0_startofpacket  (in_sop),
    .asi_in0_endofpacket    (in_eop),
    .asi_in0_ready          (in_ready),
    .aso_out0_data          (out_data),
    .aso_out0_valid         (out_valid),
    .aso_out0_startofpacket (out_sop),
    .aso_out0_endofpacket   (out_eop),
    .aso_out0_ready         (out_ready),
    .err_pulse              (err_pulse),
    .err_count              (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] sample(input int pid, input int idx);
    logic [10:0] p;
    logic [10:0] x;
    p = pid[10:0];
    x = idx[10:0];
    return {p, x};
  endfunction

  // Expected result of one packet: beats 0..e, sop at 0 and optionally at s
  task automatic model_packet(input int pid, input int e, input int s);
    int first;
    int last;
    int stop;
    first = ((s > 0) ? s : 0) + CP;
    last  = first + NF - 1;
    if (s > 0) model_errs++;
    if (e < first) begin
      model_errs++;
    end else begin
      stop = (e < last) ? e : last;
      for (int i = first; i <= stop; i++)
        exp_q.push_back({sample(pid, i), (i == first), (i == stop)});
      if (e != last) model_errs++;
    end
  endtask

  // Present one beat at a negedge and hold it until the DUT takes it
  task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
    while (gaps_on && ($urandom_range(0, 1) == 1) && !rst) @(negedge clk);
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_valid = 1'b1;
    for (int t = 0; ; t++) begin
      if (rst) break;
      if (in_ready) begin
        @(negedge clk);
        break;
      end
      if (t > 500) begin
        n_cmp++;
        n_bad++;
        $display("FAIL in_ready_timeout: ready stayed %b for %0d cycles, expected 1", in_ready, t);
        break;
      end
      in_stalls++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_packet(input int pid, input int e, input int s, input int junk);
    for (int j = 0; j < junk; j++) begin
      if (rst) break;
      send_beat(sample(2047, j), 1'b0, 1'($urandom_range(0, 1)));
    end
    model_packet(pid, e, s);
    for (int i = 0; i <= e; i++) begin
      if (rst) break;
      send_beat(sample(pid, i), (i == 0) || (s > 0 && i == s), (i == e));
    end
  endtask

  task automatic drain_check(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drain: %0d beats still expected after timeout, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
    check({tag, "_err_count"}, 64'(err_count), 64'(model_errs));
    check({tag, "_err_pulses"}, 64'(pulses_seen), 64'(model_errs));
  endtask

  // Downstream ready: constant 1 or a 50% random pattern, changed just after each edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop, stall stability and error-pulse tally
  initial begin
    bit    held_v;
    beat_t held_p;
    beat_t act;
    beat_t req;
    held_v = 1'b0;
    held_p = '0;
    forever begin
      @(negedge clk);
      act = {out_data, out_sop, out_eop};
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) check("stall_hold", {out_valid, act}, {1'b1, held_p});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got %h, expected no beat", act);
          end else begin
            req = exp_q.pop_front();
            check("out_beat", 64'(act), 64'(req));
          end
          out_total++;
        end
        held_v = out_valid && !out_ready;
        held_p = act;
        if (err_pulse) pulses_seen++;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int kind;
    int e;
    int s;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_outs", 64'({out_valid, out_sop, out_eop, out_data}), 64'd0);
    check("rst_err", 64'({err_pulse, err_count}), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_pre_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("ready_post_edge", 64'(in_ready), 64'd1);
    @(negedge clk);

    // nominal back-to-back symbols, no backpressure
    in_stalls = 0;
    for (int p = 0; p < 3; p++) send_packet(p, CP + NF - 1, 0, 0);
    drain_check("nominal");
    check("nominal_in_stalls", 64'(in_stalls), 64'd0);

    // directed malformed cases under random backpressure and input gaps
    rnd_ready = 1'b1;
    gaps_on   = 1'b1;
    send_packet(3, CP + NF - 1, 0, 0);
    send_packet(4, 40, 0, 0);
    send_packet(5, CP + NF - 1, 0, 0);
    send_packet(6, 89, 0, 0);
    send_packet(7, 10, 0, 0);
    send_packet(8, 84, 5, 0);
    send_packet(9, 0, 0, 1);
    send_packet(10, CP + NF - 1, 0, 2);
    drain_check("directed");

    // randomized mix of well-formed and malformed packets
    for (int p = 11; p < 35; p++) begin
      kind = $urandom_range(0, 5);
      s = 0;
      case (kind)
        0: e = CP + NF - 1;
        1: e = $urandom_range(CP, CP + NF - 2);
        2: e = $urandom_range(CP + NF, CP + NF + 12);
        3: e = $urandom_range(1, CP - 1);
        4: e = 0;
        default: begin
          s = $urandom_range(1, CP - 1);
          e = ($urandom_range(0, 1) == 1) ? s + CP + NF - 1 : $urandom_range(s + 1, s + CP + NF + 8);
        end
      endcase
      send_packet(p, e, s, $urandom_range(0, 2));
    end
    drain_check("random");

    // reset in the middle of a forwarded symbol
    rnd_ready = 1'b0;
    gaps_on   = 1'b0;
    base = out_total;
    fork
      send_packet(100, CP + NF - 1, 0, 0);
      begin
        for (int t = 0; t < 2000; t++) begin
          @(negedge clk);
          if (out_total >= base + 30) break;
        end
        check("mid_reset_reached", 64'(out_total >= base + 30), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_outs", 64'({out_valid, out_sop, out_eop, out_data}), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_err", 64'({err_pulse, err_count}), 64'd0);
      end
    join
    in_valid = 1'b0;
    exp_q.delete();
    model_errs  = 0;
    pulses_seen = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_ready_pre_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("mid_ready_post_edge", 64'(in_ready), 64'd1);
    @(negedge clk);
    send_packet(101, CP + NF - 1, 0, 0);
    drain_check("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ofdm_cp_remover.md
# ofdm_cp_remover

Receive-side counterpart of the OFDM cyclic-prefix insertion path. Accepts Avalon-ST packets of CP_LEN+NFFT complex samples and discards the first CP_LEN samples of each packet. Forwards the remaining NFFT samples as a new Avalon-ST packet with regenerated sop/eop. Sits between the receive sample framer and the FFT input, and flags and counts malformed packets.

## Interface
- DATA_W, 22: sample width; packed I[21:11], Q[10:0] two's complement, passed through untouched.
- NFFT, 64: useful samples per symbol; range 2..4096.
- CP_LEN, 16: prefix samples per symbol; range 1..NFFT-1.
- clk_clk  in  1  single clock; all logic on the rising edge.
- reset_reset  in  1  asynchronous, active-high reset.
- asi_in0_data  in  DATA_W  input sample.
- asi_in0_valid  in  1  input beat valid.
- asi_in0_startofpacket  in  1  first sample of a symbol, i.e. the first CP sample.
- asi_in0_endofpacket  in  1  last sample of a symbol.
- asi_in0_ready  out  1  sink ready; registered.
- aso_out0_data  out  DATA_W  output sample.
- aso_out0_valid  out  1  output beat valid.
- aso_out0_startofpacket  out  1  first useful sample.
- aso_out0_endofpacket  out  1  last useful sample.
- aso_out0_ready  in  1  downstream ready.
- err_pulse  out  1  one-cycle pulse per malformed-packet event.
- err_count  out  16  saturating count of err_pulse events.

## Operation
- Beat transfer: a beat is accepted when valid && ready. Only accepted beats advance counters or state.
- FSM states:
  - IDLE: non-sop beats are discarded silently. A sop beat goes to SKIP with cnt=1 and is itself discarded.
  - SKIP: discard beats until cnt==CP_LEN, then go to PASS with cnt=0.
  - PASS: forward beats. The first forwarded beat carries sop. The beat with cnt==NFFT-1 carries eop, and the FSM goes to IDLE.
  - DROP: discard beats until an input eop, then go to IDLE.
- CP_LEN==1 case: the sop beat goes straight to PASS.
- Well-formed input has eop exactly on the last useful sample. That eop is consumed and the FSM returns to IDLE.
- Malformed-input handling (each case raises err_pulse):
  - Input eop in SKIP: go to IDLE. Nothing is emitted.
  - Input eop in PASS before cnt==NFFT-1: forward that beat with output eop, then go to IDLE.
  - No input eop on the NFFT-th useful sample: emit output eop anyway, then go to DROP.
  - sop in SKIP: restart with cnt=1 and stay in SKIP.
  - sop in PASS: the sop bit is ignored and the beat is forwarded as data.
  - sop together with eop in IDLE: treat as a runt. Discard it and stay in IDLE.
- Counters:
  - cnt width is clog2(max(NFFT,CP_LEN+1)).
  - err_count saturates at 16'hFFFF.
  - Simultaneous events in one cycle produce a single pulse.

## Timing
- Latency: an accepted forwarded beat appears on aso_out0 the next cycle when the output stage is empty.
- Output buffer: 2-entry skid buffer.
  - asi_in0_ready = registered "skid buffer has at least one free slot".
  - No combinational path from aso_out0_ready to asi_in0_ready.
- Throughput: one beat per cycle sustained while aso_out0_ready=1. Discarded beats never consume a buffer slot.
- Output rules:
  - aso_out0_valid, data, sop and eop stay stable while valid && !ready.
  - valid never deasserts without a transfer.
- Reset values:
  - asi_in0_ready=0, aso_out0_valid/sop/eop=0, aso_out0_data=0.
  - err_pulse=0, err_count=0, FSM=IDLE, cnt=0, skid buffer empty.
  - asi_in0_ready rises on the first clock edge after reset deasserts.
- Reset mid-packet: the in-flight packet is abandoned and buffered beats are flushed. The output packet may lack eop; downstream is reset by the same signal.

## Structure
- Shared package ofdm_pkg holds:
  - DATA_W, NFFT and CP_LEN defaults, shared with the CP adder.
  - The state enumeration IDLE/SKIP/PASS/DROP.
  - The sample I/Q field slice constants.
- One sub-module, st_skid_buffer: generic 2-entry Avalon-ST skid buffer parameterised on payload width. Payload is data+sop+eop. It is reusable by the adder side.
- Top level holds the FSM, counters and error logic.

## Test plan
- Nominal: 3 back-to-back packets of 80 beats, data = beat index, NFFT=64, CP_LEN=16, out_ready=1 -> 3 output packets of 64 beats. Data is 16..79; sop on 16, eop on 79. Zero idle cycles between packets; err_count=0.
- Backpressure: same stimulus with random out_ready at 50%, random in_valid -> identical output sequence. No loss or duplication; output is held stable while stalled; asi_in0_ready never depends combinationally on out_ready.
- Short packet: eop on beat 40 of a packet -> beats 16..40 forwarded, eop on 40. One err_pulse; the next good packet is output correctly.
- Long packet: 90 beats with eop on beat 89 -> 64 beats output with eop on data 79. Beats 80..89 are dropped; err_count=1.
- Early eop and stray sop: eop at beat 10 (in CP) -> no output, err_count+1. A sop at beat 5 of the next packet restarts the CP count, so output starts at input beat 21.
- Reset mid-PASS: assert reset after 30 output beats -> all outputs 0 immediately. After release, ready=1 on the next edge and the next sop packet is processed normally.
